// File: rtl/prio_arb_rr.sv
// prio_arb_rr: registered N-way arbiter, fixed-priority or round-robin per
// arbitration, with a sticky grant held under a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        request vector, bit i = requester i
//   mode       0 = fixed priority (highest index wins), 1 = round-robin
//   gnt_ready  consumer accepts the presented grant
//   gnt_valid  a grant is presented
//   gnt_idx    index of the granted requester
//   gnt_onehot one-hot copy of gnt_idx, zero when gnt_valid = 0
module prio_arb_rr #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_onehot
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_lg;
  logic [N-1:0]     r_onehot;

  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] w_lg_nxt;
  logic [N-1:0]     w_onehot_nxt;

  logic             w_accept;
  logic             w_arb;
  logic [IDX_W-1:0] w_ptr;
  logic [IDX_W:0]   w_pos;
  logic             w_any;
  logic [IDX_W-1:0] w_win;
  logic [N-1:0]     w_win_oh;

  assign w_accept = (r_state == GRANT) & gnt_ready;

  // On an accept cycle the pointer the search uses is the index being
  // accepted, so back-to-back grants rotate without a bubble.
  // Fixed priority is the same search started from pointer 0.
  always_comb begin
    w_ptr = '0;
    if (mode) begin
      w_ptr = w_accept ? r_idx : r_lg;
    end
  end

  // Search positions ptr-1, ptr-2, ..., wrapping at 0 to N-1, ending at ptr.
  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    w_any    = 1'b0;
    w_win    = '0;
    w_win_oh = '0;
    w_pos    = '0;
    for (int k = N; k >= 1; k--) begin
      w_pos = {1'b0, w_ptr} + (IDX_W+1)'(N - k);
      if (w_pos >= (IDX_W+1)'(N)) begin
        w_pos = w_pos - (IDX_W+1)'(N);
      end
      if (req[w_pos[IDX_W-1:0]]) begin
        w_any = 1'b1;
        w_win = w_pos[IDX_W-1:0];
      end
    end
    if (w_any) begin
      w_win_oh[w_win] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_onehot_nxt = r_onehot;
    w_lg_nxt     = r_lg;
    w_arb        = 1'b0;
    unique case (r_state)
      IDLE:  w_arb = 1'b1;
      GRANT: w_arb = gnt_ready;
      default: w_arb = 1'b0;
    endcase
    if (w_accept) begin
      w_lg_nxt = r_idx;
    end
    if (w_arb) begin
      if (w_any) begin
        w_state_nxt  = GRANT;
        w_idx_nxt    = w_win;
        w_onehot_nxt = w_win_oh;
      end else begin
        w_state_nxt  = IDLE;
        w_idx_nxt    = '0;
        w_onehot_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_onehot <= '0;
      r_lg     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_onehot <= w_onehot_nxt;
      r_lg     <= w_lg_nxt;
    end
  end

  assign gnt_valid  = (r_state == GRANT);
  assign gnt_idx    = r_idx;
  assign gnt_onehot = r_onehot;

endmodule

// File: doc/prio_arb_rr.md
# prio_arb_rr

Parametrised, registered successor to the team's combinational 16:4 priority encoder. It arbitrates N request lines and produces a registered grant: an encoded index plus a one-hot vector, with a valid/ready handshake. It supports two policies, selected per arbitration: fixed priority (highest index wins, same ordering as the encoder) and round-robin (fair rotation). It sits between request sources and a shared resource. The grant is held stable until the consumer accepts it.

## Interface
Parameters:
- N, 16, number of request lines; legal range 2..256.
- IDX_W, $clog2(N), index width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i = requester i.
- mode  input  1  0 = fixed priority, 1 = round-robin; sampled only when an arbitration occurs.
- gnt_ready  input  1  consumer accepts the current grant.
- gnt_valid  output  1  a grant is presented.
- gnt_idx  output  IDX_W  index of the granted requester.
- gnt_onehot  output  N  one-hot copy of gnt_idx; all zero when gnt_valid=0.

## Operation
- State machine, two states:
  - IDLE: no grant is held.
  - GRANT: a grant is held and presented.
- Arbitration event: occurs in IDLE, or in GRANT on the accept cycle (gnt_valid & gnt_ready). It evaluates the current req and mode. If any bit of req is set, the winner is registered and the next state is GRANT; otherwise the next state is IDLE.
- Fixed priority: search order is N-1 down to 0. This is identical to the encoder ordering.
- Round-robin: a pointer lg holds the last accepted index. Search order is lg-1, lg-2, ..., 0, N-1, ..., lg (wraps from 0 to N-1). The lg requester therefore has the lowest priority.
- lg update: lg <= gnt_idx on every accept, in both modes.
- Hold rule in GRANT with gnt_ready=0: gnt_idx and gnt_onehot stay stable, and gnt_valid stays 1. This holds even if req[gnt_idx] drops, because grants are sticky.
- Mode changes take effect at the next arbitration event only.
- With req=0 at an arbitration, gnt_valid stays 0. The encoder's x output has no equivalent here.
- N that is not a power of 2: indices N..2^IDX_W-1 are never produced, and the wrap goes from 0 straight to N-1.
- Reset values: gnt_valid=0, gnt_idx=0, gnt_onehot=0, lg=0, state=IDLE.
  - With lg=0, the first round-robin search starts at N-1, which matches fixed priority.
- Reset mid-grant: the next cycle shows the reset values. The outstanding grant is dropped with no accept.

## Timing
- Latency: req asserted in cycle t while IDLE gives gnt_valid=1 in cycle t+1.
- Back-to-back: accept in cycle t with req≠0 presents the new grant in cycle t+1 with no bubble. Sustained throughput is 1 grant per cycle.
- Accept in cycle t with req=0 gives gnt_valid=0 in cycle t+1.
- All outputs come directly from flops. There is no combinational path from req, mode or gnt_ready to any output.
- rst has priority over every other input in the same cycle.

## Test plan
- Reset and idle: assert rst for 2 cycles, then hold req=0 → gnt_valid=0, gnt_idx=0 and gnt_onehot=0 every cycle.
- Fixed priority: mode=0, req=16'h8001, gnt_ready=1 held → gnt_idx=15 every grant, and index 0 is never served. Then req=16'h0021 → gnt_idx=5, gnt_onehot=16'h0020.
- Round-robin fairness: mode=1, req=16'hFFFF, gnt_ready=1 held → gnt_idx sequence 15,14,...,0,15 with one grant per cycle. Then req=16'h0105 → grants rotate 8,2,0,8.
- Handshake hold: grant idx=7 presented, gnt_ready=0 for 5 cycles, req[7] dropped in cycle 2 → idx=7 and valid=1 stay stable. On the ready cycle it is accepted, and the next grant appears the cycle after.
- Non-power-of-2 wrap: N=5, mode=1, req=5'b10001, ready held → grant sequence 4,0,4,0, and gnt_idx never exceeds 4.
- Reset mid-operation: rst asserted while valid=1 and lg=3 → next cycle valid=0. With mode=1 and req all ones, the first grant after reset is N-1.
